// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 sensor-side responder: state encoding,
// protocol phase lengths and the checksum helper.
package dht11_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_START_LOW = 3'd1;
  localparam state_t S_WAIT_GO   = 3'd2;
  localparam state_t S_RESP_LOW  = 3'd3;
  localparam state_t S_RESP_HIGH = 3'd4;
  localparam state_t S_BIT_LOW   = 3'd5;
  localparam state_t S_BIT_HIGH  = 3'd6;
  localparam state_t S_END_LOW   = 3'd7;

  localparam int T_RESP_LOW_US  = 80;
  localparam int T_RESP_HIGH_US = 80;
  localparam int T_BIT_LOW_US   = 50;
  localparam int T_BIT0_HIGH_US = 26;
  localparam int T_BIT1_HIGH_US = 70;
  localparam int T_END_LOW_US   = 50;

  localparam int FRAME_BITS = 40;
  localparam int US_CNT_W   = 21;

  // Byte sum of the payload, optionally bumped by one to provoke host errors.
  function automatic logic [7:0] dht11_csum(input logic [7:0] h_i, input logic [7:0] h_d,
                                            input logic [7:0] t_i, input logic [7:0] t_d,
                                            input logic bad);
    logic [9:0] sum;
    sum = {2'b00, h_i} + {2'b00, h_d} + {2'b00, t_i} + {2'b00, t_d};
    return sum[7:0] + {7'd0, bad};
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond tick enable: one-cycle pulse every CLK_PER_US clocks, restartable
// by a synchronous clear so every protocol phase starts on a fresh boundary.
module dht11_us_tick #(
  parameter int CLK_PER_US = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse on the open-drain line,
// answers with the presence handshake and shifts out a 40-bit frame.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int CLK_PER_US   = 50,
  parameter int MIN_START_US = 18000,
  parameter int T_GO_US      = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        dht11,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       force_bad_csum,
  output logic       busy,
  output logic       frame_done
);

  logic                  sync1, sync2;
  state_t                state, next_state;
  logic [US_CNT_W-1:0]   us_cnt;
  logic [US_CNT_W-1:0]   phase_last;
  logic                  us_tick;
  logic                  state_chg;
  logic                  phase_end;
  logic [FRAME_BITS-1:0] shreg;
  logic [5:0]            bit_idx;
  logic                  drive_low;
  logic                  done_pend;

  // Open-drain: only ever pull low, the board pull-up supplies the high level.
  assign dht11 = drive_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= dht11;
      sync2 <= sync1;
    end
  end

  assign state_chg = (next_state != state);

  dht11_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_chg),
    .tick  (us_tick)
  );

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    phase_last = US_CNT_W'(T_RESP_LOW_US - 1);
    case (state)
      S_WAIT_GO:   phase_last = US_CNT_W'(T_GO_US - 1);
      S_RESP_HIGH: phase_last = US_CNT_W'(T_RESP_HIGH_US - 1);
      S_BIT_LOW:   phase_last = US_CNT_W'(T_BIT_LOW_US - 1);
      S_BIT_HIGH:  phase_last = shreg[FRAME_BITS-1] ? US_CNT_W'(T_BIT1_HIGH_US - 1)
                                                    : US_CNT_W'(T_BIT0_HIGH_US - 1);
      S_END_LOW:   phase_last = US_CNT_W'(T_END_LOW_US - 1);
      default:     phase_last = US_CNT_W'(T_RESP_LOW_US - 1);
    endcase
  end

  assign phase_end = us_tick && (us_cnt == phase_last);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (!sync2) next_state = S_START_LOW;
      S_START_LOW: if (sync2)
                     next_state = (us_cnt >= US_CNT_W'(MIN_START_US)) ? S_WAIT_GO : S_IDLE;
      S_WAIT_GO:   if (phase_end) next_state = S_RESP_LOW;
      S_RESP_LOW:  if (phase_end) next_state = S_RESP_HIGH;
      S_RESP_HIGH: if (phase_end) next_state = S_BIT_LOW;
      S_BIT_LOW:   if (phase_end) next_state = S_BIT_HIGH;
      S_BIT_HIGH:  if (phase_end) next_state = (bit_idx == 6'd0) ? S_END_LOW : S_BIT_LOW;
      S_END_LOW:   if (phase_end) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      us_cnt <= '0;
    end else begin
      state <= next_state;
      if (state_chg)                   us_cnt <= '0;
      else if (us_tick && us_cnt != '1) us_cnt <= us_cnt + 1'b1;
    end
  end

  // Payload is captured only on the WAIT_GO exit; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (state == S_WAIT_GO && phase_end) begin
      shreg   <= {hum_int, hum_dec, temp_int, temp_dec,
                  dht11_csum(hum_int, hum_dec, temp_int, temp_dec, force_bad_csum)};
      bit_idx <= 6'(FRAME_BITS - 1);
    end else if (state == S_BIT_HIGH && phase_end && bit_idx != 6'd0) begin
      shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
      bit_idx <= bit_idx - 1'b1;
    end
  end

  // Drive enable and status follow the state register by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      drive_low  <= (state == S_RESP_LOW) || (state == S_BIT_LOW) || (state == S_END_LOW);
      busy       <= (next_state >= S_WAIT_GO);
      done_pend  <= (state == S_END_LOW) && phase_end;
      frame_done <= done_pend;
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Scoreboard bench for dht11_responder: stimulus pushes expected frames, a
// line monitor decodes the waveform and compares phase widths and frame bits.
module tb_dht11_responder;

  localparam int CPU    = 2;
  localparam int MIN_US = 200;
  localparam int TGO    = 30;
  localparam int HOST_US = 220;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_drive = 1'b0;
  logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
  logic force_bad_csum = 1'b0;
  logic busy, frame_done;
  wire  dht11_line;

  assign dht11_line = host_drive ? 1'b0 : 1'bz;
  pullup (dht11_line);

  always #5 clk = ~clk;

  dht11_responder #(.CLK_PER_US(CPU), .MIN_START_US(MIN_US), .T_GO_US(TGO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dht11          (dht11_line),
    .hum_int        (hum_int),
    .hum_dec        (hum_dec),
    .temp_int       (temp_int),
    .temp_dec       (temp_dec),
    .force_bad_csum (force_bad_csum),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int done_count = 0;
  logic [39:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done) done_count <= done_count + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic measure(input logic level, output int n);
    n = 0;
    while (dht11_line === level && rst_n && n < 400 * CPU) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Monitor: decode every DUT-initiated frame on the line.
  initial begin : monitor
    int n, lat, bad_w;
    logic [39:0] got;
    bit ok;
    forever begin
      @(negedge clk);
      if (!rst_n || host_drive || dht11_line !== 1'b0) continue;
      lat = cyc - rel_cyc;
      check("resp_latency_in_range", 64'(lat >= TGO*CPU + 2 && lat <= TGO*CPU + 4), 64'd1);
      check("busy_during_frame", 64'(busy), 64'd1);
      measure(1'b0, n); if (!rst_n) continue;
      check("resp_low_cycles", 64'(n), 64'(80*CPU));
      measure(1'b1, n); if (!rst_n) continue;
      check("resp_high_cycles", 64'(n), 64'(80*CPU));
      bad_w = 0; got = '0; ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
        measure(1'b0, n);
        if (!rst_n) begin ok = 1'b0; break; end
        if (n != 50*CPU) bad_w++;
        measure(1'b1, n);
        if (!rst_n) begin ok = 1'b0; break; end
        if (n != 26*CPU && n != 70*CPU) bad_w++;
        got = {got[38:0], (n > 48*CPU)};
      end
      if (!ok) continue;
      check("bit_phase_width_errors", 64'(bad_w), 64'd0);
      measure(1'b0, n); if (!rst_n) continue;
      check("end_low_cycles", 64'(n), 64'(50*CPU));
      check("frame_done_at_release", 64'(frame_done), 64'd1);
      @(negedge clk);
      check("frame_done_one_clk", 64'(frame_done), 64'd0);
      check("busy_after_frame", 64'(busy), 64'd0);
      if (exp_q.size() == 0) check("unexpected_frame", 64'd1, 64'd0);
      else                   check("frame_bits", 64'(got), 64'(exp_q.pop_front()));
    end
  end

  task automatic set_payload(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic bad);
    hum_int = a; hum_dec = b; temp_int = c; temp_dec = d; force_bad_csum = bad;
  endtask

  task automatic host_start(input int us);
    @(negedge clk);
    host_drive = 1'b1;
    repeat (us * CPU) @(negedge clk);
    host_drive = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!frame_done && n < 7000 * CPU) begin
      n++;
      @(negedge clk);
    end
    if (!frame_done) check(name, 64'd0, 64'd1);
    repeat (5) @(negedge clk);
  endtask

  initial begin : stimulus
    int viol;
    int done_before;

    // Reset and idle
    repeat (5) @(negedge clk);
    check("reset_line_released", 64'(dht11_line), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    viol = 0;
    repeat (300 * CPU) begin
      @(negedge clk);
      if (dht11_line !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) viol++;
    end
    check("idle_after_reset_violations", 64'(viol), 64'd0);

    // Nominal frame
    set_payload(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    exp_q.push_back(40'h37_00_19_00_50);
    host_start(HOST_US);
    wait_done("nominal_done_timeout");

    // Short start is ignored, then a normal start is answered
    host_start(100);
    viol = 0;
    repeat (400 * CPU) begin
      @(negedge clk);
      if (busy !== 1'b0 || dht11_line !== 1'b1) viol++;
    end
    check("short_start_activity", 64'(viol), 64'd0);
    exp_q.push_back(40'h37_00_19_00_50);
    host_start(HOST_US);
    wait_done("after_short_done_timeout");

    // Checksum wrap and forced bad checksum
    set_payload(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
    exp_q.push_back(40'hFF_FF_01_02_01);
    host_start(HOST_US);
    wait_done("csum_good_done_timeout");
    set_payload(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b1);
    exp_q.push_back(40'hFF_FF_01_02_02);
    host_start(HOST_US);
    wait_done("csum_bad_done_timeout");

    // Payload change during RESP_HIGH does not affect the frame
    set_payload(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    exp_q.push_back(40'h12_34_56_78_14);
    host_start(HOST_US);
    repeat ((TGO + 80 + 40) * CPU) @(negedge clk);
    set_payload(8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b1);
    wait_done("latch_done_timeout");

    // Reset in the middle of the data bits
    set_payload(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    done_before = done_count;
    host_start(HOST_US);
    repeat ((TGO + 160 + 20 * 76) * CPU) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_line_released", 64'(dht11_line), 64'd1);
    check("midreset_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200 * CPU) @(negedge clk);
    check("midreset_no_frame_done", 64'(done_count - done_before), 64'd0);
    exp_q.push_back(40'h37_00_19_00_50);
    host_start(HOST_US);
    wait_done("post_reset_done_timeout");

    check("frame_done_cycles_total", 64'(done_count), 64'd6);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
